// File: rtl/hex_display_scanner_if.sv
// Bus between the debug-word source and the hex display scanner.
// The master supplies the word and load strobe; the slave returns the scan outputs.
interface hex_display_scanner_if;
    logic [31:0] value_in;
    logic        load;
    logic [3:0]  digit_nibble;
    logic [7:0]  anode_n;
    logic [2:0]  digit_idx;
    logic        frame_done;
    logic        pending;

    modport master (
        output value_in,
        output load,
        input  digit_nibble,
        input  anode_n,
        input  digit_idx,
        input  frame_done,
        input  pending
    );

    modport slave (
        input  value_in,
        input  load,
        output digit_nibble,
        output anode_n,
        output digit_idx,
        output frame_done,
        output pending
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment scanner with frame-synchronous commit of a shadowed debug word.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_scanner_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] r_prescaler;
    logic [2:0]    r_digitIdx;
    logic [31:0]   r_shadow;
    logic [31:0]   r_disp;
    logic          r_pending;
    logic          r_frameDone;

    logic          w_tick;
    logic          w_boundary;
    logic          w_lastDigit;
    logic          w_slotLit;
    logic          w_digitShown;
    logic [7:0]    w_anode;

    assign w_tick      = (r_prescaler == PW'(REFRESH_DIV - 1));
    assign w_lastDigit = (r_digitIdx == 3'(NUM_DIGITS - 1));
    assign w_boundary  = w_tick && w_lastDigit;
    assign w_slotLit   = (r_prescaler >= PW'(BLANK_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
            r_digitIdx  <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
            r_digitIdx  <= w_lastDigit ? 3'd0 : r_digitIdx + 3'd1;
        end else begin
            r_prescaler <= r_prescaler + PW'(1);
        end
    end

    // A load on the boundary cycle commits the old shadow and keeps the new one pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_disp      <= '0;
            r_pending   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_boundary;
            if (w_boundary && r_pending) begin
                r_disp <= r_shadow;
            end
            if (bus.load) begin
                r_shadow  <= bus.value_in;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [2:0] w_msDigit;

    // Highest displayed digit holding a nonzero nibble; digit 0 when the value is zero.
    always_comb begin
        w_msDigit = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_disp[4*k +: 4] != 4'h0) begin
                w_msDigit = 3'(k);
            end
        end
    end

    assign w_digitShown = (r_digitIdx <= w_msDigit);
`else
    assign w_digitShown = 1'b1;
`endif

    always_comb begin
        w_anode = 8'hFF;
        if (w_slotLit && w_digitShown) begin
            w_anode[r_digitIdx] = 1'b0;
        end
    end

    assign bus.digit_nibble = r_disp[{r_digitIdx, 2'b00} +: 4];
    assign bus.anode_n      = w_anode;
    assign bus.digit_idx    = r_digitIdx;
    assign bus.frame_done   = r_frameDone;
    assign bus.pending      = r_pending;

endmodule
